// File: rtl/flop_bank_pkg.sv
// Shared definitions for the flop-bank arbiter: the command encoding,
// the FSM state encoding, and the pointer width helper.
package flop_bank_pkg;

  typedef enum logic [1:0] {
    CMD_HOLD   = 2'b00,
    CMD_LOAD   = 2'b01,
    CMD_PRESET = 2'b10,
    CMD_CLEAR  = 2'b11
  } cmd_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    APPLY = 2'd2
  } state_e;

  // Bits needed to index NREQ requesters; never narrower than one bit.
  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: returns the first requester with
// req high, searching upward from ptr and wrapping at NREQ.
import flop_bank_pkg::*;

module rr_pick #(
  parameter int NREQ  = 4,
  parameter int PTR_W = ptr_width(NREQ)
) (
  input  logic [NREQ-1:0]  req,
  input  logic [PTR_W-1:0] ptr,
  output logic [NREQ-1:0]  winner,
  output logic [PTR_W-1:0] win_idx
);

  // Scan requesters in priority order starting at ptr; first hit wins.
  always_comb begin : pick
    logic found;
    int   idx;
    // NOTE: every output and local gets a value before the loop, so no
    // path leaves anything unassigned and no latch is inferred.
    winner  = '0;
    win_idx = '0;
    found   = 1'b0;
    idx     = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(ptr) + k) % NREQ;
      if (!found && req[idx]) begin
        found       = 1'b1;
        winner[idx] = 1'b1;
        win_idx     = PTR_W'(idx);
      end
    end
  end

endmodule

// File: rtl/flop_bank_arb.sv
// Round-robin controller sharing one WIDTH-bit set/reset flop bank among
// NREQ requesters. One command is granted, then applied, then the FSM
// returns to IDLE, giving one command every three cycles.
import flop_bank_pkg::*;

module flop_bank_arb #(
  parameter int NREQ     = 4,
  parameter int WIDTH    = 8,
  parameter int INV_LOAD = 1
) (
  input  logic                  clk,
  input  logic                  ret,
  input  logic [NREQ-1:0]       req,
  input  logic [2*NREQ-1:0]     cmd,
  input  logic [WIDTH*NREQ-1:0] wdata,
  output logic [NREQ-1:0]       gnt,
  output logic                  busy,
  output logic                  done,
  output logic [WIDTH-1:0]      q,
  output logic [WIDTH-1:0]      p
);

  localparam int PTR_W = ptr_width(NREQ);

  state_e           state;
  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] win_idx;
  logic [PTR_W-1:0] next_ptr;
  logic [NREQ-1:0]  winner;
  logic [1:0]       sel_cmd;
  logic [WIDTH-1:0] sel_data;
  logic [WIDTH-1:0] q_next;

  rr_pick #(
    .NREQ  (NREQ),
    .PTR_W (PTR_W)
  ) u_pick (
    .req     (req),
    .ptr     (ptr),
    .winner  (winner),
    .win_idx (win_idx)
  );

  // Pointer moves one past the winner so it gets lowest priority next time.
  always_comb begin
    next_ptr = (win_idx == PTR_W'(NREQ - 1)) ? '0 : win_idx + 1'b1;
  end

  // Route the granted requester's command and data; gnt is one-hot in GRANT.
  always_comb begin
    sel_cmd  = '0;
    sel_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        sel_cmd  |= cmd[2*i +: 2];
        sel_data |= wdata[WIDTH*i +: WIDTH];
      end
    end
  end

  // Decode the selected command into the bank's next value.
  always_comb begin
    q_next = q;
    case (cmd_e'(sel_cmd))
      CMD_LOAD:   q_next = (INV_LOAD != 0) ? ~sel_data : sel_data;
      CMD_PRESET: q_next = '1;
      CMD_CLEAR:  q_next = '0;
      default:    q_next = q;
    endcase
  end

  // Arbitration FSM with registered grant, done pulse and bank value q.
  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    if (ret) begin
      state <= IDLE;
      ptr   <= '0;
      gnt   <= '0;
      done  <= 1'b0;
      q     <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (|req) begin
            gnt   <= winner;
            ptr   <= next_ptr;
            state <= GRANT;
          end else begin
            gnt <= '0;
          end
        end
        GRANT: begin
          q     <= q_next;
          gnt   <= '0;
          done  <= 1'b1;
          state <= APPLY;
        end
        APPLY: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          gnt   <= '0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  // History copy: p trails q by one clock regardless of FSM state.
  always_ff @(posedge clk) begin
    if (ret) p <= '0;
    else     p <= q;
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_flop_bank_arb.sv
// Self-checking bench for flop_bank_arb (NREQ=4, WIDTH=8, INV_LOAD=1).
// Expected grants and bank values are queued as stimulus is driven and
// popped by a monitor whenever done pulses.
module tb_flop_bank_arb;

  localparam int NREQ  = 4;
  localparam int WIDTH = 8;

  typedef struct {
    logic [NREQ-1:0]  gnt;
    logic [WIDTH-1:0] q;
    bit               chk_gap;
  } sb_item_t;

  logic                  clk = 1'b0;
  logic                  ret = 1'b1;
  logic [NREQ-1:0]       req = '0;
  logic [2*NREQ-1:0]     cmd = '0;
  logic [WIDTH*NREQ-1:0] wdata = '0;
  logic [NREQ-1:0]       gnt;
  logic                  busy;
  logic                  done;
  logic [WIDTH-1:0]      q;
  logic [WIDTH-1:0]      p;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int done_cnt = 0;
  int last_done_cyc = 0;
  bit mon_en = 1'b0;

  logic [WIDTH-1:0] prev_q   = '0;
  logic [NREQ-1:0]  prev_gnt = '0;
  logic             prev_ret = 1'b1;

  sb_item_t sb[$];

  flop_bank_arb #(
    .NREQ     (NREQ),
    .WIDTH    (WIDTH),
    .INV_LOAD (1)
  ) dut (
    .clk   (clk),
    .ret   (ret),
    .req   (req),
    .cmd   (cmd),
    .wdata (wdata),
    .gnt   (gnt),
    .busy  (busy),
    .done  (done),
    .q     (q),
    .p     (p)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic push(input logic [NREQ-1:0] g, input logic [WIDTH-1:0] qv, input bit gap);
    sb_item_t it;
    it.gnt = g;
    it.q = qv;
    it.chk_gap = gap;
    sb.push_back(it);
  endtask

  // Monitor: p history, grant shape, and scoreboard on each done pulse.
  always @(negedge clk) begin
    if (mon_en) begin
      check("gnt_onehot0", 32'($onehot0(gnt)), 32'd1);
      check("p_trails_q", 32'(p), prev_ret ? 32'd0 : 32'(prev_q));
      if (done) begin
        if (sb.size() == 0) begin
          check("unexpected_done", 32'd1, 32'd0);
        end else begin
          sb_item_t e;
          e = sb.pop_front();
          check("sb_gnt", 32'(prev_gnt), 32'(e.gnt));
          check("sb_q", 32'(q), 32'(e.q));
          if (e.chk_gap) check("grant_gap", 32'(cyc - last_done_cyc), 32'd3);
        end
        last_done_cyc = cyc;
        done_cnt++;
      end
    end
    prev_q   = q;
    prev_gnt = gnt;
    prev_ret = ret;
  end

  // One command from a single requester with fixed-latency checks.
  task automatic run_one(input int idx, input logic [1:0] c, input logic [WIDTH-1:0] d,
                         input logic [WIDTH-1:0] exp_q, input bit drop_in_grant);
    @(posedge clk); #1;
    req[idx] = 1'b1;
    cmd[2*idx +: 2] = c;
    wdata[WIDTH*idx +: WIDTH] = d;
    push(NREQ'(1) << idx, exp_q, 1'b0);
    @(posedge clk);
    if (drop_in_grant) begin #1; req[idx] = 1'b0; end
    @(negedge clk);
    check("lat_gnt", 32'(gnt), 32'(NREQ'(1) << idx));
    check("lat_busy", 32'(busy), 32'd1);
    @(posedge clk);
    if (!drop_in_grant) begin #1; req[idx] = 1'b0; end
    @(negedge clk);
    check("lat_done", 32'(done), 32'd1);
    check("lat_q", 32'(q), 32'(exp_q));
    @(negedge clk);
    check("lat_p", 32'(p), 32'(exp_q));
    check("done_cleared", 32'(done), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    bit hit;

    // Reset held two edges with every requester asking.
    req = 4'b1111;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_q", 32'(q), 32'd0);
    check("rst_p", 32'(p), 32'd0);
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    mon_en = 1'b1;
    push(4'b0001, 8'h00, 1'b0);
    @(posedge clk); #1;
    ret = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("rst_first_gnt", 32'(gnt), 32'b0001);
    @(posedge clk); #1;
    req = '0;
    repeat (3) @(posedge clk);

    // Single inverted LOAD from requester 2.
    run_one(2, 2'b01, 8'h3C, 8'hC3, 1'b0);

    // Clear, preset, clear from requester 1.
    run_one(1, 2'b11, 8'h00, 8'h00, 1'b0);
    run_one(1, 2'b10, 8'h00, 8'hFF, 1'b0);
    run_one(1, 2'b11, 8'h00, 8'h00, 1'b0);

    // Requester 3 drops req during its grant; command still lands once.
    base = done_cnt;
    run_one(3, 2'b01, 8'hF0, 8'h0F, 1'b1);
    repeat (4) @(posedge clk);
    check("drop_done_once", 32'(done_cnt - base), 32'd1);

    // Round robin with 0,1,3 held; pointer starts at 0.
    cmd   = {2'b11, 2'b00, 2'b01, 2'b10};
    wdata = {8'h00, 8'h00, 8'h5A, 8'h00};
    for (int r = 0; r < 2; r++) begin
      push(4'b0001, 8'hFF, r != 0);
      push(4'b0010, 8'hA5, 1'b1);
      push(4'b1000, 8'h00, 1'b1);
    end
    base = done_cnt;
    @(posedge clk); #1;
    req = 4'b1011;
    hit = 1'b0;
    for (int t = 0; t < 40; t++) begin
      @(posedge clk);
      if (done_cnt >= base + 6) begin hit = 1'b1; break; end
    end
    #1;
    req = '0;
    check("rr_complete", 32'(hit), 32'd1);
    repeat (4) @(posedge clk);
    check("rr_no_extra", 32'(done_cnt - base), 32'd6);

    // Reset during the GRANT of a PRESET aborts it.
    base = done_cnt;
    cmd = '0;
    wdata = '0;
    @(posedge clk); #1;
    req[0] = 1'b1;
    cmd[1:0] = 2'b10;
    @(posedge clk); #1;
    req = '0;
    ret = 1'b1;
    @(negedge clk);
    check("abort_gnt", 32'(gnt), 32'b0001);
    @(posedge clk); #1;
    ret = 1'b0;
    @(negedge clk);
    check("abort_q", 32'(q), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_gnt_clr", 32'(gnt), 32'd0);
    repeat (4) @(posedge clk);
    check("abort_no_done", 32'(done_cnt - base), 32'd0);

    // Pointer was reset: requester 0 wins over 1.
    cmd = '0;
    push(4'b0001, 8'h00, 1'b0);
    @(posedge clk); #1;
    req = 4'b0011;
    @(posedge clk);
    @(negedge clk);
    check("abort_ptr0", 32'(gnt), 32'b0001);
    @(posedge clk); #1;
    req = '0;
    repeat (4) @(posedge clk);

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
